// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file with an integrated ready (scoreboard) table.
// It provides registered reads with write bypass, combinational ready checks, and a one-cycle wakeup.
module phys_reg_file_mp #(
  parameter int unsigned NUM_PREGS = 128,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WR    = 3,
  parameter int unsigned NUM_RD    = 6,
  parameter int unsigned NUM_CHK   = 6,
  parameter int unsigned NUM_ALLOC = 3,
  localparam int unsigned TAG_W    = $clog2(NUM_PREGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*TAG_W-1:0]     wr_tag,
  input  logic [NUM_WR*DATA_W-1:0]    wr_data,
  input  logic [NUM_RD-1:0]           rd_en,
  input  logic [NUM_RD*TAG_W-1:0]     rd_tag,
  output logic [NUM_RD*DATA_W-1:0]    rd_data,
  input  logic [NUM_CHK*TAG_W-1:0]    chk_tag,
  output logic [NUM_CHK-1:0]          chk_rdy,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*TAG_W-1:0]  alloc_tag,
  input  logic                        flush,
  output logic [NUM_WR-1:0]           wake_valid,
  output logic [NUM_WR*TAG_W-1:0]     wake_tag,
  output logic                        wr_conflict
);

  logic [DATA_W-1:0]                 mem_q [NUM_PREGS];
  logic [NUM_PREGS-1:0]              ready_q, ready_d;
  logic [NUM_RD-1:0][DATA_W-1:0]     rd_q, rd_d;
  logic [NUM_WR-1:0]                 wake_valid_q;
  logic [NUM_WR-1:0][TAG_W-1:0]      wake_tag_q;
  logic                              conflict_q, conflict_d;

  logic [NUM_WR-1:0][TAG_W-1:0]      wt;
  logic [NUM_WR-1:0][DATA_W-1:0]     wd;
  logic [NUM_RD-1:0][TAG_W-1:0]      rt;
  logic [NUM_CHK-1:0][TAG_W-1:0]     ct;
  logic [NUM_ALLOC-1:0][TAG_W-1:0]   at;
  logic [NUM_WR-1:0]                 wr_act;

  assign wt = wr_tag;
  assign wd = wr_data;
  assign rt = rd_tag;
  assign ct = chk_tag;
  assign at = alloc_tag;

  // Writes to the zero register are dropped everywhere, including wakeup and bypass.
  always_comb begin
    wr_act = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_act[i] = wr_en[i] && (wt[i] != '0);
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int k = i + 1; k < NUM_WR; k++) begin
        if (wr_act[i] && wr_act[k] && (wt[i] == wt[k])) conflict_d = 1'b1;
      end
    end
  end

  // Ready priority: flush over alloc over write.
  always_comb begin
    ready_d = ready_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_act[i]) ready_d[wt[i]] = 1'b1;
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_en[a] && (at[a] != '0)) ready_d[at[a]] = 1'b0;
    end
    if (flush) ready_d = '1;
    ready_d[0] = 1'b1;
  end

  // Later write ports override earlier ones, so the highest index wins the bypass.
  always_comb begin
    rd_d = rd_q;
    for (int j = 0; j < NUM_RD; j++) begin
      if (rd_en[j]) begin
        rd_d[j] = mem_q[rt[j]];
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_act[i] && (wt[i] == rt[j])) rd_d[j] = wd[i];
        end
      end
    end
  end

  always_comb begin
    chk_rdy = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      chk_rdy[k] = ready_q[ct[k]];
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_act[i] && (wt[i] == ct[k])) chk_rdy[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PREGS; p++) begin
        mem_q[p] <= '0;
      end
      ready_q      <= '1;
      rd_q         <= '0;
      wake_valid_q <= '0;
      wake_tag_q   <= '0;
      conflict_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_act[i]) mem_q[wt[i]] <= wd[i];
      end
      ready_q    <= ready_d;
      rd_q       <= rd_d;
      conflict_q <= conflict_q | conflict_d;
      for (int i = 0; i < NUM_WR; i++) begin
        wake_valid_q[i] <= wr_act[i] && !flush;
        if (wr_act[i]) wake_tag_q[i] <= wt[i];
      end
    end
  end

  assign rd_data     = rd_q;
  assign wake_valid  = wake_valid_q;
  assign wake_tag    = wake_tag_q;
  assign wr_conflict = conflict_q;

endmodule

// File: doc/phys_reg_file_mp.md
# phys_reg_file_mp

Parametrised multi-port physical register file with integrated ready (scoreboard) table. It sits between rename/dispatch and the functional units. It provides registered operand reads with same-cycle write bypass, combinational ready checks for the reservation stations, ready clearing at allocation, and a one-cycle-delayed wakeup broadcast per write port. It adds what the previous fixed three-port version lacked: configurable port counts and depth, a hardwired zero register, deterministic write-conflict handling, and flush.

## Interface

- NUM_PREGS, 128: physical register count; power of two, ≥ 8.
- DATA_W, 32: data width.
- NUM_WR, 3: write/wakeup ports, one per FU.
- NUM_RD, 6: operand read ports.
- NUM_CHK, 6: ready-check ports.
- NUM_ALLOC, 3: allocation (set-not-ready) ports.
- TAG_W, derived $clog2(NUM_PREGS): tag width; not overridable.

- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low; asserted when 0 at a rising edge.
- wr_en  in  NUM_WR  per-port write strobe.
- wr_tag  in  NUM_WR*TAG_W  write destination tags.
- wr_data  in  NUM_WR*DATA_W  write data.
- rd_en  in  NUM_RD  per-port read strobe.
- rd_tag  in  NUM_RD*TAG_W  read source tags.
- rd_data  out  NUM_RD*DATA_W  registered read data.
- chk_tag  in  NUM_CHK*TAG_W  tags to query.
- chk_rdy  out  NUM_CHK  combinational ready result.
- alloc_en  in  NUM_ALLOC  clear-ready strobes.
- alloc_tag  in  NUM_ALLOC*TAG_W  newly renamed destination tags.
- flush  in  1  pipeline squash.
- wake_valid  out  NUM_WR  registered wakeup valid.
- wake_tag  out  NUM_WR*TAG_W  registered wakeup tags.
- wr_conflict  out  1  registered sticky error flag.

## Operation

- Storage: NUM_PREGS × DATA_W data array plus a NUM_PREGS-bit ready table.
- Tag 0 is the zero register:
  - It always reads 0 and always checks ready.
  - Writes to it are dropped, with no wakeup.
  - Allocs to it are ignored.
- Write: if wr_en[i] and wr_tag ≠ 0, the data and ready[tag]=1 update at the edge.
- Same-tag writes in one cycle from several ports: the highest-index port wins the data. wr_conflict is set and stays set until reset. All colliding ports still raise wake_valid.
- Read: if rd_en[j], rd_data[j] is loaded at the edge with array[rd_tag]. If a write to the same tag is active in that cycle, the write data is loaded instead (bypass; highest write port wins). If rd_en[j]=0, rd_data[j] holds its value.
- Ready check: chk_rdy[k] = ready[chk_tag[k]] OR (any active write to chk_tag[k] this cycle). Checks ignore alloc in the same cycle. All check ports are independent, with no check-enable.
- Alloc: if alloc_en[a], ready[alloc_tag]=0 at the edge.
- Ready-bit priority for the same tag in the same cycle: flush > alloc > write. Alloc winning means the newly renamed producer owns the tag. The data array still takes the write.
- Flush:
  - At the edge, every ready bit is set to 1.
  - wake_valid is all 0 next cycle.
  - Writes and reads in the flush cycle still update the data array and rd_data.
  - Alloc in the flush cycle is ignored.
- Wakeup: wake_valid[i] / wake_tag[i] register the cycle-N write of port i (tag ≠ 0) and are visible in cycle N+1. With no write, wake_valid[i]=0 and wake_tag[i] holds.

## Timing

- Reset, sampled at an edge with reset=0:
  - Data array is all 0; ready table is all 1.
  - rd_data = 0, wake_valid = 0, wake_tag = 0, wr_conflict = 0.
  - All other inputs are ignored that cycle.
- Reset takes priority mid-operation. Any write, alloc or flush in the reset cycle is discarded.
- chk_rdy is zero-latency combinational from chk_tag, ready and wr_*. There is no path from alloc_* or flush to chk_rdy.
- Read latency is 1 cycle. Write-to-read is 0 cycles through the bypass.
- Alloc takes effect for checks in cycle N+1. Write readiness is visible in cycle N through the bypass and from the table in N+1.
- Wakeup latency is exactly 1 cycle after the write.
- Throughput: every port can be used every cycle.

## Test plan

- Reset: hold reset=0 for 2 cycles, release.
  - Every tag checks ready; every read returns 0.
  - wake_valid=0, wr_conflict=0.
- Alloc → write → wakeup:
  - Alloc tag 37 in cycle 0: chk 37 reads 0 in cycle 1.
  - Write port 1 tag 37 data 0xDEADBEEF in cycle 2: chk 37 reads 1 in cycle 2 (bypass).
  - Cycle 3: wake_valid[1]=1, wake_tag[1]=37.
  - Read tag 37 in cycle 3: rd_data=0xDEADBEEF in cycle 4.
- Bypass: write tag 5 = 0x1234 and read tag 5 in the same cycle → rd_data=0x1234 next cycle.
- Zero register: write tag 0 = 0xFFFF_FFFF and alloc tag 0 → read returns 0, chk_rdy=1, wake_valid=0.
- Conflict: ports 0 and 2 both write tag 9, with 0xAAAA and 0xBBBB.
  - Read of tag 9 returns 0xBBBB.
  - wr_conflict=1 and stays 1 until reset.
  - wake_valid[0] and wake_valid[2] are both 1.
- Priority and flush:
  - Alloc and write tag 12 in the same cycle → ready[12]=0 next cycle.
  - Then flush, together with alloc of tag 20 (while 12 and 20 are not ready): next cycle 12 and 20 both check ready, and wake_valid=0.
